// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding, opcodes,
// datapath mux encodings and the per-state control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RWB,
        ADDI_EX,
        ADDI_WB,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Outputs that depend on the state alone; input-qualified strobes live in the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ADDI_WB: c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.alu_op        = ALUOP_SUB;
                c.pc_source     = PCSRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            JUMP: begin
                c.pc_source = PCSRC_JUMP;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Illegal opcodes fall back to FETCH; the PC was already advanced in FETCH.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW: s = MEMADR;
            OP_RTYPE:     s = EXEC;
            OP_ADDI:      s = ADDI_EX;
            OP_BEQ:       s = BRANCH;
            OP_J:         s = JUMP;
            default:      s = FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Counts cycles a memory state spends waiting for ready; flags the last allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic timeout
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // A ready in the final cycle still completes the access.
    assign timeout = busy & ~ready & (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (busy && !ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller sequencing a shared-memory multicycle MIPS datapath, with
// memory-wait timeout and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);
    state_t           r_state;
    state_t           w_state_next;
    ctrl_t            r_ctrl;
    logic             r_is_store;
    logic [CNT_W-1:0] r_instr_count;

    logic w_in_mem;
    logic w_timeout;
    logic w_clear;
    logic w_retire;
    logic w_unused;

    // The branch condition is applied by the datapath's pc_write_cond gate.
    assign w_unused = zero;

    assign w_in_mem = is_mem_state(r_state);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .busy    (w_in_mem),
        .ready   (mem_ready),
        .timeout (w_timeout)
    );

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH: begin
                if (mem_ready)      w_state_next = DECODE;
                else if (w_timeout) w_state_next = FETCH;
            end
            DECODE:  w_state_next = decode_target(opcode);
            MEMADR:  w_state_next = r_is_store ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready)      w_state_next = MEMWB;
                else if (w_timeout) w_state_next = FETCH;
            end
            MEMWR: begin
                if (mem_ready) begin
                    w_state_next = FETCH;
                    w_retire     = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = FETCH;
                end
            end
            EXEC:    w_state_next = RWB;
            ADDI_EX: w_state_next = ADDI_WB;
            MEMWB, RWB, ADDI_WB, BRANCH, JUMP: begin
                w_state_next = FETCH;
                w_retire     = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Re-entering FETCH after a timeout must restart the wait budget too.
    assign w_clear = is_mem_state(w_state_next) && ((w_state_next != r_state) || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ctrl        <= '0;
            r_is_store    <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= ctrl_for(w_state_next);
            if (r_state == DECODE) begin
                r_is_store <= (opcode == OP_SW);
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign mem_req       = r_ctrl.mem_req;
    assign mem_we        = r_ctrl.mem_we;
    assign iord          = r_ctrl.iord;
    assign pc_write_cond = r_ctrl.pc_write_cond;
    assign pc_source     = r_ctrl.pc_source;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign alu_op        = r_ctrl.alu_op;
    assign reg_dst       = r_ctrl.reg_dst;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign reg_write     = r_ctrl.reg_write;

    assign ir_write    = (r_state == FETCH) & mem_ready;
    assign pc_write    = r_ctrl.pc_write | ir_write;
    assign mdr_write   = (r_state == MEMRD) & mem_ready;
    assign illegal_op  = (r_state == DECODE) & ~is_legal(opcode);
    assign bus_err     = w_timeout;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected outputs are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_BAD  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond;
    logic [1:0]       pc_source, alu_src_b, alu_op;
    logic             alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, bus_err;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op),
        .bus_err       (bus_err),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             iord;
        logic             ir_write;
        logic             mdr_write;
        logic             pc_write;
        logic             pc_write_cond;
        logic [1:0]       pc_source;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       alu_op;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             illegal_op;
        logic             bus_err;
        logic [CNT_W-1:0] count;
    } obs_t;

    obs_t             exp_q[$];
    string            tag_q[$];
    int               total = 0;
    int               bad = 0;
    logic [CNT_W-1:0] exp_count;

    // Expected output words, written directly from the state table.
    function automatic obs_t o_idle();
        obs_t o; o = '0; return o;
    endfunction
    function automatic obs_t o_fetch(input logic rdy, input logic to);
        obs_t o; o = '0;
        o.mem_req = 1'b1; o.alu_src_b = 2'b01;
        o.ir_write = rdy; o.pc_write = rdy; o.bus_err = to;
        return o;
    endfunction
    function automatic obs_t o_decode(input logic ill);
        obs_t o; o = '0; o.alu_src_b = 2'b11; o.illegal_op = ill; return o;
    endfunction
    function automatic obs_t o_addr();
        obs_t o; o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; return o;
    endfunction
    function automatic obs_t o_memrd(input logic rdy, input logic to);
        obs_t o; o = '0;
        o.mem_req = 1'b1; o.iord = 1'b1; o.mdr_write = rdy; o.bus_err = to;
        return o;
    endfunction
    function automatic obs_t o_memwb();
        obs_t o; o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; return o;
    endfunction
    function automatic obs_t o_memwr(input logic to);
        obs_t o; o = '0;
        o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; o.bus_err = to;
        return o;
    endfunction
    function automatic obs_t o_exec();
        obs_t o; o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b10; return o;
    endfunction
    function automatic obs_t o_rwb();
        obs_t o; o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; return o;
    endfunction
    function automatic obs_t o_addiwb();
        obs_t o; o = '0; o.reg_write = 1'b1; return o;
    endfunction
    function automatic obs_t o_branch();
        obs_t o; o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_write_cond = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_jump();
        obs_t o; o = '0; o.pc_source = 2'b10; o.pc_write = 1'b1; return o;
    endfunction

    // One cycle: drive inputs, queue the expected outputs, advance the clock.
    task automatic step(input string tag, input logic [5:0] opc, input logic z,
                        input logic rdy, input obs_t e, input bit retire);
        opcode    = opc;
        zero      = z;
        mem_ready = rdy;
        e.count   = exp_count;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (retire) exp_count = exp_count + 1'b1;
    endtask

    task automatic run_lw();
        step("lw fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("lw decode", C_LW,  1'b0, 1'b1, o_decode(1'b0), 1'b0);
        step("lw memadr", C_SW,  1'b0, 1'b1, o_addr(), 1'b0);
        step("lw memrd",  C_SW,  1'b0, 1'b1, o_memrd(1'b1, 1'b0), 1'b0);
        step("lw memwb",  C_BAD, 1'b0, 1'b1, o_memwb(), 1'b1);
    endtask

    task automatic run_r();
        step("r fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("r decode", C_R,   1'b0, 1'b0, o_decode(1'b0), 1'b0);
        step("r exec",   C_BAD, 1'b0, 1'b1, o_exec(), 1'b0);
        step("r rwb",    C_BAD, 1'b0, 1'b1, o_rwb(), 1'b1);
    endtask

    task automatic run_beq(input logic z);
        step("beq fetch",  C_BAD, z, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("beq decode", C_BEQ, z, 1'b1, o_decode(1'b0), 1'b0);
        step("beq branch", C_BAD, z, 1'b1, o_branch(), 1'b1);
    endtask

    task automatic run_j();
        step("j fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("j decode", C_J,   1'b0, 1'b0, o_decode(1'b0), 1'b0);
        step("j jump",   C_BAD, 1'b0, 1'b1, o_jump(), 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond,
                 pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                 reg_write, illegal_op, bus_err, instr_count};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h", t, a, e);
            end else begin
                $display("ok   %s: outputs %h", t, a);
            end
        end
    end

    initial begin
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        step("in reset", C_BAD, 1'b0, 1'b1, o_idle(), 1'b0);
        rst_n = 1'b1;
        step("idle after reset", C_BAD, 1'b0, 1'b1, o_idle(), 1'b0);

        run_lw();
        run_r();
        run_beq(1'b1);
        run_beq(1'b0);

        // Store with three wait cycles; ready lands on the last allowed cycle.
        step("sw fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("sw decode", C_SW,  1'b0, 1'b1, o_decode(1'b0), 1'b0);
        step("sw memadr", C_LW,  1'b0, 1'b1, o_addr(), 1'b0);
        for (int i = 0; i < 3; i++)
            step("sw memwr wait", C_BAD, 1'b0, 1'b0, o_memwr(1'b0), 1'b0);
        step("sw memwr ready", C_BAD, 1'b0, 1'b1, o_memwr(1'b0), 1'b1);

        step("addi fetch",   C_BAD,  1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("addi decode",  C_ADDI, 1'b0, 1'b1, o_decode(1'b0), 1'b0);
        step("addi ex",      C_BAD,  1'b0, 1'b1, o_addr(), 1'b0);
        step("addi wb",      C_BAD,  1'b0, 1'b1, o_addiwb(), 1'b1);

        // Fetch timeout, then a fresh wait budget on re-entry.
        for (int i = 0; i < 3; i++)
            step("fetch wait", C_BAD, 1'b0, 1'b0, o_fetch(1'b0, 1'b0), 1'b0);
        step("fetch timeout", C_BAD, 1'b0, 1'b0, o_fetch(1'b0, 1'b1), 1'b0);
        step("refetch wait", C_BAD, 1'b0, 1'b0, o_fetch(1'b0, 1'b0), 1'b0);
        run_j();

        // Load whose data phase times out: no retire.
        step("lwto fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("lwto decode", C_LW,  1'b0, 1'b1, o_decode(1'b0), 1'b0);
        step("lwto memadr", C_BAD, 1'b0, 1'b1, o_addr(), 1'b0);
        for (int i = 0; i < 3; i++)
            step("lwto memrd wait", C_BAD, 1'b0, 1'b0, o_memrd(1'b0, 1'b0), 1'b0);
        step("lwto memrd timeout", C_BAD, 1'b0, 1'b0, o_memrd(1'b0, 1'b1), 1'b0);

        step("ill fetch",  C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("ill decode", C_BAD, 1'b0, 1'b1, o_decode(1'b1), 1'b0);

        // Count is 7 here; nine jumps carry it through all-ones to zero.
        for (int i = 0; i < 9; i++) run_j();

        step("wrap fetch", C_BAD, 1'b0, 1'b1, o_fetch(1'b1, 1'b0), 1'b0);
        step("rst sw decode", C_SW, 1'b0, 1'b1, o_decode(1'b0), 1'b0);
        step("rst sw memadr", C_BAD, 1'b0, 1'b1, o_addr(), 1'b0);
        step("rst sw memwr wait", C_BAD, 1'b0, 1'b0, o_memwr(1'b0), 1'b0);

        // Reset mid-wait with no clock edge before the monitor samples.
        mem_ready = 1'b0;
        #1;
        rst_n     = 1'b0;
        exp_count = '0;
        exp_q.push_back(o_idle());
        tag_q.push_back("async reset in memwr");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle after mid reset", C_BAD, 1'b0, 1'b1, o_idle(), 1'b0);
        run_j();
        step("count after j", C_BAD, 1'b0, 1'b0, o_fetch(1'b0, 1'b0), 1'b0);

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
